// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    TIMEOUT  = 2'd3
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forward select for one E-stage source: M beats W, x0 never forwards.
// Purely combinational, zero latency; no flow control.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rd_m,
  input  logic             reg_write_m,
  input  logic [WIDTH-1:0] rd_w,
  input  logic             reg_write_w,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs))
      sel = FWD_MEM;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: post-reset scrub, load-use bubble, redirect flush, mem-wait freeze + watchdog.
// Stall/flush/forward are combinational from state and inputs; mem_timeout is registered and sticky.
// Optional HAZARD_PERF_EN adds stall/flush/freeze performance counters (tied to 0 otherwise).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WIDTH              = 5,
  parameter int RESET_FLUSH_CYCLES = 2,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Rs1D,
  input  logic [WIDTH-1:0] Rs2D,
  input  logic [WIDTH-1:0] Rs1E,
  input  logic [WIDTH-1:0] Rs2E,
  input  logic [WIDTH-1:0] RdE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic [WIDTH-1:0] RdM,
  input  logic             RegWriteM,
  input  logic [WIDTH-1:0] RdW,
  input  logic             RegWriteW,
  input  logic             mem_busy,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt,
  output logic [31:0]      perf_freeze_cnt
);

  localparam int WD_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  hz_state_t       state;
  logic [3:0]      init_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_inc;
  logic            wd_hit;
  logic            lw_stall;
  logic            freeze;
  logic            run_rules;

  hazard_fwd_sel #(.WIDTH(WIDTH)) u_fwd_a (
    .rs(Rs1E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .sel(ForwardAE)
  );

  hazard_fwd_sel #(.WIDTH(WIDTH)) u_fwd_b (
    .rs(Rs2E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .sel(ForwardBE)
  );

  assign lw_stall  = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign freeze    = (((state == RUN) || (state == MEM_WAIT)) && mem_busy) || (state == TIMEOUT);
  assign run_rules = ((state == RUN) || (state == MEM_WAIT)) && !mem_busy;

  // The busy cycle seen in RUN is the first one counted by the watchdog.
  always_comb begin
    if (state == RUN)
      wd_inc = WD_W'(1);
    else if (wd_cnt == '1)
      wd_inc = wd_cnt;
    else
      wd_inc = wd_cnt + WD_W'(1);
  end

  assign wd_hit = (TIMEOUT_CYCLES != 0) && (wd_inc == WD_W'(TIMEOUT_CYCLES));

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (state == INIT) begin
      StallF = 1'b1;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (run_rules && PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (run_rules && lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      init_cnt    <= 4'(RESET_FLUSH_CYCLES);
      wd_cnt      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (init_cnt <= 4'd1)
            state <= RUN;
          if (init_cnt != 4'd0)
            init_cnt <= init_cnt - 4'd1;
        end
        RUN, MEM_WAIT: begin
          if (mem_busy) begin
            wd_cnt <= wd_inc;
            if (wd_hit) begin
              state       <= TIMEOUT;
              mem_timeout <= 1'b1;
            end else begin
              state <= MEM_WAIT;
            end
          end else begin
            wd_cnt <= '0;
            state  <= RUN;
          end
        end
        TIMEOUT: state <= TIMEOUT;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_freeze_cnt <= '0;
    end else begin
      if (run_rules && !PCSrcE && lw_stall)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (run_rules && PCSrcE)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (freeze)
        perf_freeze_cnt <= perf_freeze_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt  = 32'd0;
  assign perf_flush_cnt  = 32'd0;
  assign perf_freeze_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       MemReadE, PCSrcE, RegWriteM, RegWriteW, mem_busy;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt;

  int errors = 0;
  int checks = 0;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,ForwardAE,ForwardBE,mem_timeout}
  logic [10:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.WIDTH(5), .RESET_FLUSH_CYCLES(2), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .mem_busy(mem_busy),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_freeze_cnt(perf_freeze_cnt)
  );

  function automatic logic [10:0] mk(input logic sf, sd, se, sm, fd, fe,
                                     input logic [1:0] fa, fb, input logic to);
    return {sf, sd, se, sm, fd, fe, fa, fb, to};
  endfunction

  localparam logic [10:0] E_IDLE   = 11'b0;
  localparam logic [10:0] E_INIT   = {6'b100011, 5'b00000};
  localparam logic [10:0] E_LW     = {6'b110001, 5'b00000};
  localparam logic [10:0] E_REDIR  = {6'b000011, 5'b00000};
  localparam logic [10:0] E_FREEZE = {6'b111100, 5'b00000};
  localparam logic [10:0] E_TMO    = {6'b111100, 5'b00001};

  // Monitor: every cycle the DUT presents a response at negedge; compare against the queue head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [10:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, mem_timeout};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got SF/SD/SE/SM/FD/FE=%b FA=%b FB=%b TO=%b, expected %b FA=%b FB=%b TO=%b",
                 nm, a[10:5], a[4:3], a[2:1], a[0], e[10:5], e[4:3], e[2:1], e[0]);
      end
    end
  end

  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    MemReadE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; mem_busy = 0;
  endtask

  // Inputs are set by the caller just after a posedge; expectation covers this cycle.
  task automatic cyc(input string nm, input logic [10:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    clr();
    @(posedge clk);
    #1;
    cyc("rst_hold0", E_INIT);
    cyc("rst_hold1", E_INIT);
    rst = 1'b0;
    cyc("init_cycle1", E_INIT);
    cyc("init_cycle2", E_INIT);
    cyc("run_idle", E_IDLE);

    // Load-use hazards
    MemReadE = 1; RdE = 5; Rs1D = 5;
    cyc("lw_rs1", E_LW);
    MemReadE = 0;
    cyc("lw_gone", E_IDLE);
    MemReadE = 1; RdE = 9; Rs1D = 0; Rs2D = 9;
    cyc("lw_rs2", E_LW);
    RdE = 0; Rs1D = 0; Rs2D = 0;
    cyc("lw_rd0", E_IDLE);
    clr();

    // Forwarding priority
    RegWriteM = 1; RegWriteW = 1; RdM = 7; RdW = 7; Rs1E = 7; Rs2E = 3;
    cyc("fwd_a_mem", mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
    RegWriteM = 0;
    cyc("fwd_a_wb", mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0));
    RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0;
    cyc("fwd_x0", E_IDLE);
    RdM = 3; RdW = 3; Rs1E = 4; Rs2E = 3;
    cyc("fwd_b_mem", mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0));
    RdM = 6;
    cyc("fwd_b_wb", mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0));
    clr();

    // Redirect beats load-use
    PCSrcE = 1; MemReadE = 1; RdE = 5; Rs1D = 5;
    cyc("redir_over_lw", E_REDIR);
    clr();

    // Freeze with pending branch, then redirect on release
    PCSrcE = 1; mem_busy = 1; MemReadE = 1; RdE = 5; Rs1D = 5;
    cyc("freeze1", E_FREEZE);
    cyc("freeze2", E_FREEZE);
    cyc("freeze3", E_FREEZE);
    mem_busy = 0; MemReadE = 0;
    cyc("freeze_release_redir", E_REDIR);
    clr();
    cyc("after_release_idle", E_IDLE);

    // Watchdog: timeout after the 4th busy cycle, sticky until reset
    mem_busy = 1;
    for (int i = 1; i <= 10; i++)
      cyc($sformatf("busy%0d", i), (i <= 4) ? E_FREEZE : E_TMO);
    mem_busy = 0; PCSrcE = 1;
    cyc("tmo_sticky1", E_TMO);
    cyc("tmo_sticky2", E_TMO);
    rst = 1'b1;
    cyc("rst_in_timeout", E_INIT);
    rst = 1'b0; PCSrcE = 0;
    cyc("reinit1", E_INIT);
    cyc("reinit2", E_INIT);
    cyc("rerun_idle", E_IDLE);

    // Reset during a load-use stall, forwarding still live in INIT
    MemReadE = 1; RdE = 5; Rs1D = 5;
    cyc("lw_before_rst", E_LW);
    rst = 1'b1; RegWriteW = 1; RdW = 2; Rs2E = 2;
    cyc("rst_mid_stall", mk(1, 0, 0, 0, 1, 1, 2'b00, 2'b01, 0));
    rst = 1'b0;
    cyc("init_fwd", mk(1, 0, 0, 0, 1, 1, 2'b00, 2'b01, 0));
    cyc("init_fwd2", mk(1, 0, 0, 0, 1, 1, 2'b00, 2'b01, 0));
    clr();
    cyc("final_idle", E_IDLE);

    // Drain: the monitor must have consumed every expectation
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
